// File: rtl/uart_report_if.sv
// Handshake and data bundle between a report requester and the uart_report_tx serializer.
// The master drives the request and digits; the slave returns the serial line and status.
interface uart_report_if;
    logic       send;
    logic [3:0] mode;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output send, mode, dig0, dig1, dig2, dig3, input tx, busy, done);
    modport slave  (input send, mode, dig0, dig1, dig2, dig3, output tx, busy, done);
endinterface

// File: rtl/uart_report_tx.sv
// Serializes a six-byte ASCII status report (mode char, four hex digits, CR) as 8N1 UART.
// Inputs are latched at acceptance; tx, busy and done all come straight from flops.
module uart_report_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    uart_report_if.slave rif
);
    localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

    function automatic logic [7:0] mode_char(input logic [3:0] m);
        case (m)
            4'b0001: mode_char = 8'h21;
            4'b0010: mode_char = 8'h40;
            4'b0100: mode_char = 8'h23;
            4'b1000: mode_char = 8'h24;
            default: mode_char = 8'h3F;
        endcase
    endfunction

    // 'A' is 8'h41, so digits 10..15 map to 8'h37 + d.
    function automatic logic [7:0] hex_char(input logic [3:0] d);
        if (d < 4'd10) begin
            hex_char = 8'h30 + {4'h0, d};
        end else begin
            hex_char = 8'h37 + {4'h0, d};
        end
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_q,  baud_d;
    logic [2:0]       bit_q,   bit_d;
    logic [2:0]       byte_q,  byte_d;
    logic [3:0]       mode_q,  mode_d;
    logic [15:0]      dig_q,   dig_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [7:0]       cur_byte_s;
    logic [2:0]       next_bit_s;

    // Byte currently on the wire, selected from the latched snapshot.
    always_comb begin
        case (byte_q)
            3'd0:    cur_byte_s = mode_char(mode_q);
            3'd1:    cur_byte_s = hex_char(dig_q[15:12]);
            3'd2:    cur_byte_s = hex_char(dig_q[11:8]);
            3'd3:    cur_byte_s = hex_char(dig_q[7:4]);
            3'd4:    cur_byte_s = hex_char(dig_q[3:0]);
            default: cur_byte_s = 8'h0D;
        endcase
    end

    // Next-state logic; tx_d is the level tx must show in the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        mode_d     = mode_q;
        dig_d      = dig_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        next_bit_s = bit_q + 3'd1;
        case (state_q)
            IDLE: begin
                if (rif.send) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    mode_d  = rif.mode;
                    dig_d   = {rif.dig3, rif.dig2, rif.dig1, rif.dig0};
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = cur_byte_s[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit_s;
                        tx_d  = cur_byte_s[next_bit_s];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_q == 3'd5) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame with the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            mode_q  <= 4'd0;
            dig_q   <= 16'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            mode_q  <= mode_d;
            dig_q   <= dig_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rif.tx   = tx_q;
    assign rif.busy = busy_q;
    assign rif.done = done_q;
endmodule

// File: doc/uart_report_tx.md
UART_REPORT_TX -- requirements
Module: uart_report_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port send  input  1  request to transmit one report frame; sampled each clk.
REQ-005 SHALL have port mode  input  4  one-hot current mode (0001, 0010, 0100, 1000).
REQ-006 SHALL have port dig0, dig1, dig2, dig3  input  4 each  display digits; dig3 is most significant.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL transmit a frame of 6 bytes, in order: mode char, dig3, dig2, dig1, dig0, 8'h0D.
REQ-011 SHALL encode the mode char as 0001->8'h21 '!', 0010->8'h40 '@', 0100->8'h23 '#', 1000->8'h24 '$', and any other value->8'h3F '?'.
REQ-012 SHALL encode each digit as ASCII hex: 0-9->8'h30+d, 10-15->8'h41+(d-10).
REQ-013 SHALL accept send only when busy=0; at acceptance it SHALL latch mode and dig0..dig3, and later input changes SHALL NOT affect the frame.
REQ-014 SHALL ignore send while busy=1, with no queuing.
REQ-015 SHALL raise busy on the clk edge that accepts send; the start bit SHALL begin on tx in that same cycle.
REQ-016 SHALL use a bit FSM with states IDLE, START, DATA, STOP; each of START, every DATA bit and STOP SHALL last exactly CLKS_PER_BIT cycles.
REQ-017 SHALL drive tx=0 in START, data bit[i] for i=0..7 in DATA, and tx=1 in STOP and IDLE.
REQ-018 SHALL go from STOP of byte k<5 directly to START of byte k+1, with no idle gap between bytes.
REQ-019 SHALL make a frame last exactly 60*CLKS_PER_BIT cycles from acceptance to the end of the last stop bit.
REQ-020 SHALL, on the cycle after the last stop bit ends, return to IDLE, drive busy=0 and pulse done=1 for one cycle.
REQ-021 SHALL accept send asserted in the same cycle done pulses, starting a new frame immediately.
REQ-022 SHALL size the baud counter to hold CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; the byte index SHALL count 0..5 and the bit index 0..7.
REQ-023 SHALL register tx, busy and done, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, on rst=1, immediately and asynchronously force tx=1, busy=0, done=0, FSM=IDLE, and clear all counters and latched bytes.
REQ-025 SHALL abort a frame in progress when rst is asserted mid-frame, without completing the byte and without a done pulse.
REQ-026 SHALL accept send on the first clk edge after rst deasserts, if send is high.

Verification (CLKS_PER_BIT=4)
REQ-027 SHALL be verified for a basic frame: mode=0001, dig3..0=1,2,3,4, send pulse -> bytes 21,31,32,33,34,0D decoded from tx; busy high for 240 cycles; one done pulse.
REQ-028 SHALL be verified for encoding: mode=0110, digits A,F,0,9 -> bytes 3F,41,46,30,39,0D.
REQ-029 SHALL be verified for request handling: send held high continuously -> frames back-to-back, each 240 cycles, no idle between frames; a send pulse mid-frame -> ignored, one frame only.
REQ-030 SHALL be verified for input latching: mode changed from 0100 to 1000 one cycle after acceptance -> first byte still 23.
REQ-031 SHALL be verified for reset mid-frame: rst asserted during byte 2 DATA -> tx=1 and busy=0 asynchronously, no done pulse; a new send afterwards -> a complete correct frame.
REQ-032 SHALL be verified for bit timing: every tx transition lands on a multiple of 4 cycles from acceptance, and the start bit is low for exactly 4 cycles.
